// File: rtl/mtrx_transform.sv
// ============================================================================
// Module   : mtrx_transform
// Function : R = T x V for 4x4 Q1.10.5 matrices on one shared MAC unit, with
//            an atomic commit of the result, overflow flag and state code.
// Revision : 1.0
// ============================================================================
`default_nettype none

module mtrx_transform (
  input  logic         CLK,
  input  logic         rst,
  input  logic         start,
  input  logic [255:0] tIn,
  input  logic [255:0] vIn,
  input  logic [3:0]   stateIn,
  output logic         busy,
  output logic         done,
  output logic         ovf,
  output logic [255:0] mtrxOut,
  output logic [3:0]   matrixState
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_MAC    = 2'd1,
    S_COMMIT = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_next;

  logic [255:0]        r_t;
  logic [255:0]        r_v;
  logic [3:0]          r_st;
  logic [15:0]         r_scr [0:15];
  logic signed [33:0]  r_acc;
  logic [1:0]          r_i;
  logic [1:0]          r_j;
  logic [1:0]          r_k;
  logic                r_wovf;
  logic                r_done;
  logic                r_ovf;
  logic [255:0]        r_mtrx;
  logic [3:0]          r_mstate;

  logic [7:0]          w_toff;
  logic [7:0]          w_voff;
  logic signed [15:0]  w_t;
  logic signed [15:0]  w_v;
  logic signed [31:0]  w_prod;
  logic signed [33:0]  w_sum;
  logic signed [33:0]  w_shf;
  logic [15:0]         w_sat;
  logic                w_sat_flag;
  logic [255:0]        w_pack;
  logic                w_last;

  // Element n = 4*col + row sits at bit offset 16*(15-n), i.e. {~n, 4'b0}.
  assign w_toff = {~{r_k, r_i}, 4'b0000};
  assign w_voff = {~{r_j, r_k}, 4'b0000};
  assign w_t    = r_t[w_toff +: 16];
  assign w_v    = r_v[w_voff +: 16];
  assign w_prod = w_t * w_v;
  assign w_sum  = r_acc + {{2{w_prod[31]}}, w_prod};
  assign w_shf  = w_sum >>> 5;
  assign w_last = (r_i == 2'd3) && (r_j == 2'd3) && (r_k == 2'd3);

  always_comb begin
    w_sat      = w_shf[15:0];
    w_sat_flag = 1'b0;
    if (w_shf > 34'sd32767) begin
      w_sat      = 16'h7FFF;
      w_sat_flag = 1'b1;
    end else if (w_shf < -34'sd32768) begin
      w_sat      = 16'h8000;
      w_sat_flag = 1'b1;
    end
  end

  always_comb begin
    w_pack = '0;
    for (int n = 0; n < 16; n++) begin
      w_pack[(15 - n) * 16 +: 16] = r_scr[n];
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (start) w_next = S_MAC;
      S_MAC:    if (w_last) w_next = S_COMMIT;
      S_COMMIT: w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_ff @(posedge CLK or posedge rst) begin
    if (rst) begin
      r_t      <= '0;
      r_v      <= '0;
      r_st     <= '0;
      r_acc    <= '0;
      r_i      <= '0;
      r_j      <= '0;
      r_k      <= '0;
      r_wovf   <= 1'b0;
      r_done   <= 1'b0;
      r_ovf    <= 1'b0;
      r_mtrx   <= '0;
      r_mstate <= '0;
      for (int n = 0; n < 16; n++) begin
        r_scr[n] <= '0;
      end
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_t    <= tIn;
            r_v    <= vIn;
            r_st   <= stateIn;
            r_acc  <= '0;
            r_wovf <= 1'b0;
            r_i    <= '0;
            r_j    <= '0;
            r_k    <= '0;
          end
        end
        S_MAC: begin
          if (r_k == 2'd3) begin
            r_scr[{r_j, r_i}] <= w_sat;
            r_acc             <= '0;
            if (w_sat_flag) r_wovf <= 1'b1;
          end else begin
            r_acc <= w_sum;
          end
          // Counters wrap naturally: k inner, i middle, j outer.
          r_k <= r_k + 2'd1;
          if (r_k == 2'd3) begin
            r_i <= r_i + 2'd1;
            if (r_i == 2'd3) r_j <= r_j + 2'd1;
          end
        end
        S_COMMIT: begin
          r_mtrx   <= w_pack;
          r_mstate <= r_st;
          r_ovf    <= r_wovf;
          r_done   <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign busy        = (r_state != S_IDLE);
  assign done        = r_done;
  assign ovf         = r_ovf;
  assign mtrxOut     = r_mtrx;
  assign matrixState = r_mstate;

endmodule

`default_nettype wire
